// File: rtl/mipi_csi_rx_packet_decoder_8b2lane_if.sv
// Byte-stream input and decoded payload/header outputs of the 2-lane CSI-2 packet decoder.
interface mipi_csi_rx_packet_decoder_8b2lane_if;
    logic        data_valid_i;
    logic [15:0] data_i;
    logic        output_valid_o;
    logic [15:0] data_o;
    logic [15:0] packet_length_o;
    logic [2:0]  packet_type_o;

    modport master (
        output data_valid_i,
        output data_i,
        input  output_valid_o,
        input  data_o,
        input  packet_length_o,
        input  packet_type_o
    );

    modport slave (
        input  data_valid_i,
        input  data_i,
        output output_valid_o,
        output data_o,
        output packet_length_o,
        output packet_type_o
    );
endinterface

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane.sv
// MIPI CSI-2 RX long-packet decoder for a 2-lane, byte-aligned stream: strips header/CRC, forwards payload.
// Optional macro MIPI_CSI_RX_VC_FILTER_EN: only virtual channel 0 headers are accepted.
module mipi_csi_rx_packet_decoder_8b2lane (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    mipi_csi_rx_packet_decoder_8b2lane_if.slave  bus
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DT_W   = 6;
    localparam int unsigned TYPE_W = 3;

    localparam logic [WORD_W-1:0] SYNC_WORD = 16'hB8B8;
    localparam logic [WORD_W-1:0] BYTES_PER_WORD = 16'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR0     = 3'd1,
        HDR1     = 3'd2,
        PAYLOAD  = 3'd3,
        WAIT_END = 3'd4
    } state_t;

    state_t              state_q;
    logic [DT_W-1:0]     dt_q;
    logic [BYTE_W-1:0]   wc_lo_q;
    logic [WORD_W-1:0]   remaining_q;
    logic                output_valid_q;
    logic [WORD_W-1:0]   data_q;
    logic [WORD_W-1:0]   packet_length_q;
    logic [TYPE_W-1:0]   packet_type_q;
`ifdef MIPI_CSI_RX_VC_FILTER_EN
    logic [1:0]          vc_q;
`endif

    logic [TYPE_W-1:0]   type_code_c;
    logic [WORD_W-1:0]   hdr_wc_c;
    logic                hdr_ok_c;

    // Header decode: map data type to output code and judge whether the packet is forwarded.
    always_comb begin
        type_code_c = '0;
        case (dt_q)
            6'h2A:   type_code_c = TYPE_W'(1);
            6'h2B:   type_code_c = TYPE_W'(2);
            6'h2C:   type_code_c = TYPE_W'(3);
            6'h2D:   type_code_c = TYPE_W'(4);
            6'h1E:   type_code_c = TYPE_W'(5);
            default: type_code_c = '0;
        endcase
        hdr_wc_c = {bus.data_i[BYTE_W-1:0], wc_lo_q};
        hdr_ok_c = (type_code_c != '0) && (hdr_wc_c != '0);
`ifdef MIPI_CSI_RX_VC_FILTER_EN
        if (vc_q != 2'b00) begin
            hdr_ok_c = 1'b0;
        end
`endif
    end

    // Packet state machine with registered outputs; dropping data_valid_i always returns to IDLE.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            dt_q            <= '0;
            wc_lo_q         <= '0;
            remaining_q     <= '0;
            output_valid_q  <= 1'b0;
            data_q          <= '0;
            packet_length_q <= '0;
            packet_type_q   <= '0;
`ifdef MIPI_CSI_RX_VC_FILTER_EN
            vc_q            <= '0;
`endif
        end else begin
            output_valid_q <= 1'b0;
            if (!bus.data_valid_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= (bus.data_i == SYNC_WORD) ? HDR0 : WAIT_END;
                    end
                    HDR0: begin
                        dt_q    <= bus.data_i[DT_W-1:0];
                        wc_lo_q <= bus.data_i[WORD_W-1:BYTE_W];
`ifdef MIPI_CSI_RX_VC_FILTER_EN
                        vc_q    <= bus.data_i[BYTE_W-1:DT_W];
`endif
                        state_q <= HDR1;
                    end
                    HDR1: begin
                        // Upper lane byte is the header ECC; it is intentionally not checked.
                        if (hdr_ok_c) begin
                            packet_length_q <= hdr_wc_c;
                            packet_type_q   <= type_code_c;
                            remaining_q     <= hdr_wc_c;
                            state_q         <= PAYLOAD;
                        end else begin
                            state_q <= WAIT_END;
                        end
                    end
                    PAYLOAD: begin
                        data_q         <= bus.data_i;
                        output_valid_q <= 1'b1;
                        if (remaining_q <= BYTES_PER_WORD) begin
                            remaining_q <= '0;
                            state_q     <= WAIT_END;
                        end else begin
                            remaining_q <= remaining_q - BYTES_PER_WORD;
                        end
                    end
                    WAIT_END: begin
                        state_q <= WAIT_END;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.output_valid_o  = output_valid_q;
    assign bus.data_o          = data_q;
    assign bus.packet_length_o = packet_length_q;
    assign bus.packet_type_o   = packet_type_q;

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_8b2lane.sv
// Scoreboard bench for the 2-lane CSI-2 packet decoder: expected payload words queued at stimulus time.
module tb_mipi_csi_rx_packet_decoder_8b2lane;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    always #5 clk_i = ~clk_i;

    mipi_csi_rx_packet_decoder_8b2lane_if bus ();

    mipi_csi_rx_packet_decoder_8b2lane dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int out_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] stim_q[$];
    logic [15:0] exp_len  = 16'd0;
    logic [2:0]  exp_type = 3'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every output word must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (!reset_i && bus.output_valid_o === 1'b1) begin
            out_cnt++;
            if (exp_q.size() == 0)
                check("extra_word", 32'(bus.data_o), 32'hFFFF_FFFF);
            else
                check("payload", 32'(bus.data_o), 32'(exp_q.pop_front()));
        end
    end

    task automatic drive(input logic v, input logic [15:0] d);
        @(posedge clk_i);
        #1;
        bus.data_valid_i = v;
        bus.data_i       = d;
    endtask

    // Sync, header (ECC byte arbitrary), payload and trailing words; expectations for the first npay words.
    task automatic build_pkt(input logic [7:0] di, input logic [15:0] wc, input bit accept,
                             input int npay, input int tail);
        logic [15:0] w;
        stim_q.push_back(16'hB8B8);
        stim_q.push_back({wc[7:0], di});
        stim_q.push_back({8'hA5, wc[15:8]});
        for (int i = 0; i < npay + tail; i++) begin
            w = (i == 1) ? 16'hB8B8 : 16'($urandom);
            stim_q.push_back(w);
            if (accept && i < npay) exp_q.push_back(w);
        end
    endtask

    task automatic send_stim();
        out_cnt = 0;
        foreach (stim_q[i]) drive(1'b1, stim_q[i]);
        stim_q.delete();
    endtask

    task automatic finish_pkt(input string tag, input int exp_cnt);
        drive(1'b0, 16'h0000);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check({tag, "_cnt"}, 32'(out_cnt), 32'(exp_cnt));
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_len"}, 32'(bus.packet_length_o), 32'(exp_len));
        check({tag, "_type"}, 32'(bus.packet_type_o), 32'(exp_type));
        exp_q.delete();
    endtask

    task automatic std_pkt(input string tag, input logic [7:0] di, input logic [15:0] wc,
                           input bit accept, input logic [2:0] code);
        int n;
        n = accept ? int'((wc + 16'd1) >> 1) : 0;
        build_pkt(di, wc, accept, n, 2);
        if (accept) begin
            exp_len  = wc;
            exp_type = code;
        end
        send_stim();
        finish_pkt(tag, n);
    endtask

    initial begin
        bus.data_valid_i = 1'b0;
        bus.data_i       = 16'h0000;
        #23;
        check("rst_ov",   32'(bus.output_valid_o),  32'd0);
        check("rst_data", 32'(bus.data_o),          32'd0);
        check("rst_len",  32'(bus.packet_length_o), 32'd0);
        check("rst_type", 32'(bus.packet_type_o),   32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Reference RAW10 stream; valid stays high over CRC/filler.
        stim_q = '{16'hB8B8, 16'h062B, 16'hDD00, 16'hFFEE, 16'h3322, 16'h0000, 16'h0FA0, 16'h1111, 16'hB8B8};
        exp_q  = '{16'hFFEE, 16'h3322, 16'h0000};
        exp_len = 16'd6; exp_type = 3'd2;
        send_stim();
        finish_pkt("raw10_ref", 3);

        // Stream not starting with sync is ignored until valid drops.
        stim_q = '{16'h1234, 16'hB8B8, 16'h062B, 16'hDD00, 16'hFFEE, 16'h3322, 16'h0000, 16'h0FA0};
        send_stim();
        finish_pkt("nosync", 0);
        std_pkt("resync", 8'h2B, 16'd6, 1'b1, 3'd2);

        std_pkt("raw8_odd", 8'h2A, 16'd5, 1'b1, 3'd1);
        std_pkt("short",    8'h12, 16'd0, 1'b0, 3'd0);
        std_pkt("raw12",    8'h2C, 16'd7, 1'b1, 3'd3);
        std_pkt("raw14",    8'h2D, 16'd8, 1'b1, 3'd4);
        std_pkt("yuv422",   8'h1E, 16'd4, 1'b1, 3'd5);
        std_pkt("unsup",    8'h2E, 16'd4, 1'b0, 3'd0);
        std_pkt("wc_zero",  8'h2A, 16'd0, 1'b0, 3'd0);
        std_pkt("raw8_one", 8'h2A, 16'd1, 1'b1, 3'd1);
`ifdef MIPI_CSI_RX_VC_FILTER_EN
        std_pkt("vc1",      8'h6B, 16'd4, 1'b0, 3'd0);
`else
        std_pkt("vc1",      8'h6B, 16'd4, 1'b1, 3'd2);
`endif

        // Abort mid-payload by dropping valid after 10 of 128 words.
        build_pkt(8'h2B, 16'h0100, 1'b1, 10, 0);
        exp_len = 16'h0100; exp_type = 3'd2;
        send_stim();
        drive(1'b0, 16'h0000);
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_ov", 32'(bus.output_valid_o), 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("abort_cnt",   32'(out_cnt),     32'd10);
        check("abort_drain", 32'(exp_q.size()), 32'd0);
        std_pkt("after_abort", 8'h2A, 16'd2, 1'b1, 3'd1);

        // Asynchronous reset in the middle of a payload.
        build_pkt(8'h2A, 16'd20, 1'b1, 3, 0);
        exp_len = 16'd20; exp_type = 3'd1;
        send_stim();
        drive(1'b1, 16'h7777);
        #5;
        reset_i = 1'b1;
        #1;
        check("arst_ov",   32'(bus.output_valid_o),  32'd0);
        check("arst_data", 32'(bus.data_o),          32'd0);
        check("arst_len",  32'(bus.packet_length_o), 32'd0);
        check("arst_type", 32'(bus.packet_type_o),   32'd0);
        check("arst_cnt",  32'(out_cnt),             32'd3);
        check("arst_drain", 32'(exp_q.size()),       32'd0);
        exp_len = 16'd0; exp_type = 3'd0;
        @(negedge clk_i);
        reset_i = 1'b0;
        stim_q = '{16'h1357, 16'h2468, 16'h9999, 16'hB8B8, 16'h042A, 16'h0000, 16'h1111};
        send_stim();
        finish_pkt("post_reset", 0);
        std_pkt("recover", 8'h2C, 16'd9, 1'b1, 3'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mipi_csi_rx_packet_decoder_8b2lane.md
MIPI_CSI_RX_PACKET_DECODER_8B2LANE -- requirements
Module: mipi_csi_rx_packet_decoder_8b2lane

Interface
REQ-001 SHALL use one clock and an asynchronous active-high reset.
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 data_valid_i  input  1  lane-aligned byte stream valid; rises on sync word, falls after packet end.
REQ-005 data_i  input  16  [7:0] = lane 0 byte, [15:8] = lane 1 byte.
REQ-006 output_valid_o  output  1  high while data_o carries payload of an accepted long packet.
REQ-007 data_o  output  16  payload word, same lane order as data_i.
REQ-008 packet_length_o  output  16  word count (WC, bytes) of the most recent accepted header.
REQ-009 packet_type_o  output  3  encoded data type of the most recent accepted header.

Function
REQ-010 SHALL implement states IDLE, HDR0, HDR1, PAYLOAD, WAIT_END.
REQ-011 IDLE: data_valid_i=1 and data_i=16'hB8B8 -> HDR0; data_valid_i=1 with any other word -> WAIT_END; else stay.
REQ-012 HDR0: latch DI=data_i[7:0], WC[7:0]=data_i[15:8] -> HDR1.
REQ-013 HDR1: WC[15:8]=data_i[7:0]; data_i[15:8] (ECC) ignored, not checked.
REQ-014 HDR1 exit: DI[5:0] in {0x1E,0x2A,0x2B,0x2C,0x2D} and WC!=0 -> PAYLOAD; otherwise (short packet, unsupported type, WC=0) -> WAIT_END.
REQ-015 On PAYLOAD entry: packet_length_o<=WC; packet_type_o<=1 (0x2A RAW8), 2 (0x2B RAW10), 3 (0x2C RAW12), 4 (0x2D RAW14), 5 (0x1E YUV422 8-bit); both held until next accepted header.
REQ-016 PAYLOAD: data_o<=data_i and output_valid_o<=1 each cycle, i.e. 1-cycle latency from input word to output word.
REQ-017 16-bit remaining-byte counter loaded with WC, decremented by 2 per payload word; word consumed with remaining<=2 is last -> WAIT_END.
REQ-018 Number of output words = ceil(WC/2); odd WC: final word output complete, only [7:0] meaningful.
REQ-019 Input words after the last payload word (CRC, filler) SHALL NOT be output.
REQ-020 output_valid_o low in every cycle following a non-PAYLOAD state cycle; data_o holds last value when output_valid_o=0.
REQ-021 WAIT_END: stay until data_valid_i=0 -> IDLE.
REQ-022 data_valid_i=0 in any state -> IDLE next cycle; mid-payload this aborts, output_valid_o=0 next cycle, no further words.
REQ-023 Sync word detection only in IDLE; B8B8 inside payload is ordinary data.

Reset
REQ-024 Reset SHALL force state IDLE, output_valid_o=0, data_o=0, packet_length_o=0, packet_type_o=0, counter=0, immediately and independent of clk_i.
REQ-025 Reset mid-packet discards the packet; after release a new sync word is required.

Configuration
REQ-026 MIPI_CSI_RX_VC_FILTER_EN defined: headers with DI[7:6]!=2'b00 treated as unsupported (-> WAIT_END, outputs unchanged).
REQ-027 MIPI_CSI_RX_VC_FILTER_EN undefined: virtual channel bits DI[7:6] ignored; all VCs accepted.

Verification
REQ-028 valid=1 with B8B8, 062B, DD00, FFEE, 3322, 0000, 0FA0... -> packet_type_o=2, packet_length_o=6, output_valid_o high exactly 3 cycles with data_o FFEE, 3322, 0000; then low though valid stays 1.
REQ-029 Same stream, first valid word 1234 -> no output; after valid low then B8B8 header, packet decoded normally.
REQ-030 Header 052A/xx00 (RAW8, WC=5) -> packet_type_o=1, packet_length_o=5, 3 output words.
REQ-031 Header 0012/xx00 (short packet type 0x12) -> output_valid_o stays 0, packet_length_o/packet_type_o keep prior values.
REQ-032 RAW10 WC=0x0100, data_valid_i dropped after 10 payload words -> exactly 10 output words, output_valid_o=0 next cycle, state IDLE.
REQ-033 reset_i pulsed mid-payload asynchronously -> all outputs 0 before next clock edge; macro build: DI=0x6B header -> no output.
